argmax_frame_ctrl: RTL and testbench

- Sequences the 10-class argmax stage at the BNN output.
- Accepts class scores serially from the output layer over a valid/ready stream and packs them into the 100-bit score vector.
- Launches one argmax evaluation per frame, captures the winning index, and holds it on a valid/ready result port until the downstream consumer accepts it.
- Also handles framing errors and a watchdog on the argmax response.

---
 rtl/bnn_cls_pkg.sv | 28 ++
 rtl/argmax_frame_buf.sv | 51 +++++
 rtl/argmax_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_argmax_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_cls_pkg.sv
// -----------------------------------------------------------------------------
// bnn_cls_pkg
// Shared constants and types for the BNN classifier output stage.
//   - Default class count, score width and index width.
//   - Default argmax response watchdog limit.
//   - Frame-controller state encoding: COLLECT=0, LAUNCH=1, WAIT=2, OUT=3.
//   - vec_w(): width of the packed score vector handed to the argmax unit.
// -----------------------------------------------------------------------------
package bnn_cls_pkg;

   localparam int NUM_CLASSES_DEF = 10;
   localparam int SCORE_W_DEF     = 10;
   localparam int IDX_W_DEF       = 4;
   localparam int TIMEOUT_DEF     = 15;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_WAIT    = 2'd2,
      ST_OUT     = 2'd3
   } frame_state_e;

   // Packed score-vector width: one SCORE_W field per class.
   function automatic int vec_w(input int num_classes, input int score_w);
      return num_classes * score_w;
   endfunction

endpackage

// File: rtl/argmax_frame_buf.sv
// -----------------------------------------------------------------------------
// argmax_frame_buf
// Write-indexed score register file for one frame. Slot k holds the score of
// class k and is presented on data_o at bits [k*SCORE_W +: SCORE_W].
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset (clears every slot)
//   we_i    in   write enable for slot idx_i
//   idx_i   in   slot index (out-of-range indices are ignored)
//   data_i  in   score to store
//   clr_i   in   synchronous clear of every slot; wins over we_i
//   data_o  out  packed contents of all slots
// -----------------------------------------------------------------------------
module argmax_frame_buf
   import bnn_cls_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int SCORE_W     = SCORE_W_DEF,
   parameter int IDX_W       = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we_i,
   input  logic [IDX_W-1:0]               idx_i,
   input  logic [SCORE_W-1:0]             data_i,
   input  logic                           clr_i,
   output logic [NUM_CLASSES*SCORE_W-1:0] data_o
);

   logic [NUM_CLASSES-1:0][SCORE_W-1:0] mem_q;

   // NOTE: this storage is reset because the argmax input must read all-zero
   // after reset; a plain register file would normally be left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
      end else if (clr_i) begin
         mem_q <= '0;
      end else if (we_i) begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            if (idx_i == IDX_W'(k)) begin
               mem_q[k] <= data_i;
            end
         end
      end
   end

   assign data_o = mem_q;

endmodule

// File: rtl/argmax_frame_ctrl.sv
// -----------------------------------------------------------------------------
// argmax_frame_ctrl
// Frames the serial class scores coming out of the BNN output layer, launches
// one argmax evaluation per complete frame, and holds the winning index on a
// valid/ready result port until it is consumed. Flags framing errors and
// argmax response timeouts with a one-cycle o_err pulse.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   s_valid     in   score beat valid
//   s_ready     out  controller accepts a beat (COLLECT only)
//   s_score     in   class score, beat k is class k
//   s_last      in   final beat of the frame
//   am_i_valid  out  one-cycle launch pulse to argmax
//   am_i_data   out  packed scores, class k at [k*SCORE_W +: SCORE_W]
//   am_o_idx    in   argmax result index
//   am_o_valid  in   argmax result valid
//   m_valid     out  result valid
//   m_ready     in   downstream accepts result
//   m_idx       out  winning class
//   o_err       out  one-cycle error pulse
//   o_busy      out  high in every state except COLLECT
//   o_frames    out  (ARGMAX_CTRL_STATS_EN) accepted results, wraps
//   o_errs      out  (ARGMAX_CTRL_STATS_EN) error pulses, saturates at 255
//
// Build option: define ARGMAX_CTRL_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module argmax_frame_ctrl
   import bnn_cls_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int SCORE_W     = SCORE_W_DEF,
   parameter int IDX_W       = IDX_W_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [SCORE_W-1:0]                   s_score,
   input  logic                                 s_last,
   output logic                                 am_i_valid,
   output logic [vec_w(NUM_CLASSES,SCORE_W)-1:0] am_i_data,
   input  logic [IDX_W-1:0]                     am_o_idx,
   input  logic                                 am_o_valid,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [IDX_W-1:0]                     m_idx,
   output logic                                 o_err,
   output logic                                 o_busy
`ifdef ARGMAX_CTRL_STATS_EN
   ,
   output logic [15:0]                          o_frames,
   output logic [7:0]                           o_errs
`endif
);

   localparam int CNT_W = $clog2(NUM_CLASSES);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   frame_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic             buf_clr;
   logic             beat_acc;

   assign beat_acc = s_valid && (state_q == ST_COLLECT);

   argmax_frame_buf #(
      .NUM_CLASSES (NUM_CLASSES),
      .SCORE_W     (SCORE_W),
      .IDX_W       (CNT_W)
   ) u_buf (
      .clk    (clk),
      .rst    (rst),
      .we_i   (beat_acc),
      .idx_i  (cnt_q),
      .data_i (s_score),
      .clr_i  (buf_clr),
      .data_o (am_i_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_COLLECT;
         cnt_q   <= '0;
         to_q    <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      to_d       = to_q;
      idx_d      = idx_q;
      err_d      = 1'b0;
      buf_clr    = 1'b0;
      s_ready    = 1'b0;
      am_i_valid = 1'b0;
      m_valid    = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (cnt_q == CNT_W'(NUM_CLASSES - 1)) begin
                  // A full frame is evaluated even when s_last is missing;
                  // the missing marker is still reported.
                  state_d = ST_LAUNCH;
                  cnt_d   = '0;
                  err_d   = !s_last;
               end else if (s_last) begin
                  // Short frame: drop it and restart collection.
                  cnt_d   = '0;
                  err_d   = 1'b1;
                  buf_clr = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_LAUNCH: begin
            am_i_valid = 1'b1;
            to_d       = '0;
            state_d    = ST_WAIT;
         end

         ST_WAIT: begin
            if (am_o_valid) begin
               idx_d   = am_o_idx;
               state_d = ST_OUT;
            end else begin
               to_d = to_q + TO_W'(1);
               if (to_d == TO_W'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  buf_clr = 1'b1;
                  state_d = ST_COLLECT;
               end
            end
         end

         ST_OUT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               cnt_d   = '0;
               buf_clr = 1'b1;
               state_d = ST_COLLECT;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_COLLECT;
         end
      endcase
   end

   assign m_idx  = idx_q;
   assign o_err  = err_q;
   assign o_busy = (state_q != ST_COLLECT);

`ifdef ARGMAX_CTRL_STATS_EN
   logic [15:0] frames_q;
   logic [7:0]  errs_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frames_q <= '0;
         errs_q   <= '0;
      end else begin
         if (m_valid && m_ready) begin
            frames_q <= frames_q + 16'd1;
         end
         if (err_q && (errs_q != 8'hFF)) begin
            errs_q <= errs_q + 8'd1;
         end
      end
   end

   assign o_frames = frames_q;
   assign o_errs   = errs_q;
`endif

endmodule

// File: tb/tb_argmax_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_argmax_frame_ctrl
// Directed bench for argmax_frame_ctrl with a one-cycle argmax stub.
// Define ARGMAX_CTRL_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_argmax_frame_ctrl;

   localparam int N  = 10;
   localparam int W  = 10;
   localparam int IW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           s_valid;
   logic           s_ready;
   logic [W-1:0]   s_score;
   logic           s_last;
   logic           am_i_valid;
   logic [N*W-1:0] am_i_data;
   logic [IW-1:0]  am_o_idx;
   logic           am_o_valid;
   logic           m_valid;
   logic           m_ready;
   logic [IW-1:0]  m_idx;
   logic           o_err;
   logic           o_busy;
`ifdef ARGMAX_CTRL_STATS_EN
   logic [15:0]    o_frames;
   logic [7:0]     o_errs;
`endif

   int errors = 0;
   int checks = 0;
   int err_pulses = 0;
   int launch_pulses = 0;

   logic [W-1:0] sc [N];

   // Argmax stub: one-cycle response, first maximum wins; can be muted, and a
   // stray response can be injected directly.
   logic          stub_en;
   logic          stub_v = 1'b0;
   logic [IW-1:0] stub_idx = '0;
   logic          inj_v;
   logic [IW-1:0] inj_idx;

   function automatic logic [IW-1:0] ref_argmax(input logic [N*W-1:0] v);
      int best = 0;
      for (int k = 1; k < N; k++) begin
         if (v[k*W +: W] > v[best*W +: W]) best = k;
      end
      return IW'(best);
   endfunction

   function automatic logic [N*W-1:0] exp_vec();
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = sc[k];
      return v;
   endfunction

   always @(posedge clk) begin
      stub_v   <= am_i_valid && stub_en;
      stub_idx <= ref_argmax(am_i_data);
   end

   assign am_o_valid = stub_v | inj_v;
   assign am_o_idx   = inj_v ? inj_idx : stub_idx;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_err === 1'b1) err_pulses++;
      if (am_i_valid === 1'b1) launch_pulses++;
   end

   argmax_frame_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_score    (s_score),
      .s_last     (s_last),
      .am_i_valid (am_i_valid),
      .am_i_data  (am_i_data),
      .am_o_idx   (am_o_idx),
      .am_o_valid (am_o_valid),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_idx      (m_idx),
      .o_err      (o_err),
      .o_busy     (o_busy)
`ifdef ARGMAX_CTRL_STATS_EN
      ,
      .o_frames   (o_frames),
      .o_errs     (o_errs)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives n beats from sc[]; s_last on beat last_at (-1: never).
   // Returns #1 after the edge that accepted the last driven beat.
   task automatic send_beats(input int n, input int last_at);
      for (int k = 0; k < n; k++) begin
         s_valid = 1'b1;
         s_score = sc[k];
         s_last  = (k == last_at);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_score = '0;
   endtask

   // Called in the LAUNCH cycle; returns in the first OUT cycle.
   task automatic run_tail(input logic [IW-1:0] exp_idx, input logic exp_err, input string tag);
      check({tag, "_launch_valid"}, 128'(am_i_valid), 128'(1'b1));
      check({tag, "_launch_data"},  128'(am_i_data),  128'(exp_vec()));
      check({tag, "_launch_sready"}, 128'(s_ready),   128'(1'b0));
      check({tag, "_launch_busy"},  128'(o_busy),     128'(1'b1));
      check({tag, "_launch_err"},   128'(o_err),      128'(exp_err));
      @(posedge clk); #1;
      check({tag, "_wait"}, 128'({am_i_valid, m_valid, o_busy}), 128'(3'b001));
      @(posedge clk); #1;
      check({tag, "_out_valid"}, 128'(m_valid), 128'(1'b1));
      check({tag, "_out_idx"},   128'(m_idx),   128'(exp_idx));
   endtask

   initial begin
      int e0;
      int l0;

      rst     = 1'b1;
      s_valid = 1'b0;
      s_score = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      stub_en = 1'b1;
      inj_v   = 1'b0;
      inj_idx = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_sready", 128'(s_ready),    128'(1'b1));
      check("rst_amv",    128'(am_i_valid), 128'(1'b0));
      check("rst_amdata", 128'(am_i_data),  128'(0));
      check("rst_mvalid", 128'(m_valid),    128'(1'b0));
      check("rst_midx",   128'(m_idx),      128'(0));
      check("rst_err",    128'(o_err),      128'(1'b0));
      check("rst_busy",   128'(o_busy),     128'(1'b0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Nominal frame, result taken on OUT entry
      m_ready = 1'b1;
      sc = '{10'd5, 10'd17, 10'd3, 10'd900, 10'd12, 10'd0, 10'd1, 10'd899, 10'd44, 10'd2};
      e0 = err_pulses;
      send_beats(10, 9);
      run_tail(4'd3, 1'b0, "nom");
      @(posedge clk); #1;
      check("nom_done", 128'({m_valid, s_ready, o_busy}), 128'(3'b010));
      check("nom_no_err", 128'(err_pulses - e0), 128'(0));

      // Result back-pressure
      m_ready = 1'b0;
      sc = '{10'd5, 10'd17, 10'd3, 10'd100, 10'd12, 10'd0, 10'd1, 10'd899, 10'd44, 10'd2};
      send_beats(10, 9);
      run_tail(4'd7, 1'b0, "bp");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_hold", 128'({m_valid, m_idx, s_ready}), 128'({1'b1, 4'd7, 1'b0}));
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", 128'({m_valid, s_ready, o_busy}), 128'(3'b010));

      // Early s_last on beat 4
      sc = '{10'd50, 10'd60, 10'd70, 10'd80, 10'd90, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
      l0 = launch_pulses;
      send_beats(5, 4);
      check("early_err", 128'({o_err, o_busy, s_ready}), 128'(3'b101));
      @(posedge clk); #1;
      check("early_err_pulse", 128'(o_err), 128'(1'b0));
      check("early_no_launch", 128'(launch_pulses - l0), 128'(0));

      // Full frame after the dropped one, max at class 9
      sc = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd1023};
      send_beats(10, 9);
      run_tail(4'd9, 1'b0, "c9");
      @(posedge clk); #1;

      // Missing s_last, all-equal scores
      sc = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100};
      send_beats(10, -1);
      run_tail(4'd0, 1'b1, "nolast");
      @(posedge clk); #1;
      check("nolast_done", 128'({m_valid, o_busy}), 128'(2'b00));

      // Argmax never responds
      stub_en = 1'b0;
      sc = '{10'd5, 10'd17, 10'd3, 10'd900, 10'd12, 10'd0, 10'd1, 10'd899, 10'd44, 10'd2};
      send_beats(10, 9);
      check("to_launch", 128'(am_i_valid), 128'(1'b1));
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         check("to_wait", 128'({o_busy, m_valid, o_err}), 128'(3'b100));
      end
      @(posedge clk); #1;
      check("to_abort", 128'({o_err, o_busy, s_ready, m_valid}), 128'(4'b1010));

      // Reset during WAIT, then a stale argmax response
      send_beats(10, 9);
      @(posedge clk); #1;
      check("rw_in_wait", 128'(o_busy), 128'(1'b1));
      rst = 1'b1;
      #1;
      check("rw_outs", 128'({o_busy, s_ready, m_valid, am_i_valid, o_err, m_idx}),
            128'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
      check("rw_amdata", 128'(am_i_data), 128'(0));
      @(posedge clk); #1;
      rst     = 1'b0;
      stub_en = 1'b1;
      inj_v   = 1'b1;
      inj_idx = 4'd5;
      @(posedge clk); #1;
      inj_v = 1'b0;
      check("stale_ignored", 128'({o_busy, m_valid, m_idx}), 128'({1'b0, 1'b0, 4'd0}));

      // Reset during OUT
      m_ready = 1'b0;
      sc = '{10'd5, 10'd17, 10'd3, 10'd900, 10'd12, 10'd0, 10'd1, 10'd899, 10'd44, 10'd2};
      send_beats(10, 9);
      run_tail(4'd3, 1'b0, "ro");
      rst = 1'b1;
      #1;
      check("ro_outs", 128'({m_valid, m_idx, s_ready, o_busy}), 128'({1'b0, 4'd0, 1'b1, 1'b0}));
      @(posedge clk); #1;
      rst     = 1'b0;
      m_ready = 1'b1;

`ifdef ARGMAX_CTRL_STATS_EN
      check("st_reset", 128'({o_frames, o_errs}), 128'({16'd0, 8'd0}));
      for (int f = 0; f < 3; f++) begin
         send_beats(10, 9);
         repeat (3) begin
            @(posedge clk); #1;
         end
      end
      for (int f = 0; f < 2; f++) begin
         send_beats(3, 2);
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("st_frames", 128'(o_frames), 128'(16'd3));
      check("st_errs",   128'(o_errs),   128'(8'd2));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
